vga_timing_gen: RTL and testbench

Raster timing source for the VGA display path. It produces the `pixelx`/`pixely` scan coordinates that every sprite block consumes, and drives the hsync, vsync and blanking outputs toward the DAC. It also registers the composited 24-bit colour coming back from the sprite layer, aligned to the sync outputs, so that sprite ROM read latency is absorbed here. Default timing is 640x480@60 from a 50 MHz system clock.

---
 rtl/vga_timing_gen.sv | 118 +++++++++++
 tb/tb_vga_timing_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing source: scan counters, sync/blank decode delayed PIPE_DELAY pixels, registered colour.
// Latency: PIPE_DELAY pixel periods from coordinate to sync/blank/rgb outputs; no backpressure (free-running).
module vga_timing_gen #(
   parameter int CLK_DIV    = 2,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int PIPE_DELAY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] rgb_in,
   output logic [9:0]  pixelx,
   output logic [9:0]  pixely,
   output logic        pix_tick,
   output logic        frame_start,
   output logic        hsync,
   output logic        vsync,
   output logic        blank_n,
   output logic [23:0] rgb_out,
   output logic        vga_clk
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = $clog2(CLK_DIV);

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
   } sync_t;

   localparam sync_t SYNC_IDLE = sync_t'(3'b110);

   logic [DIV_W-1:0] div;
   sync_t            raw;
   sync_t            last_in;
   sync_t            stage [PIPE_DELAY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   assign pix_tick    = (div == DIV_LAST);
   assign vga_clk     = (div >= DIV_HALF);
   assign frame_start = pix_tick && (pixelx == H_LAST) && (pixely == V_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixelx <= '0;
         pixely <= '0;
      end else if (pix_tick) begin
         if (pixelx == H_LAST) begin
            pixelx <= '0;
            pixely <= (pixely == V_LAST) ? 10'd0 : pixely + 10'd1;
         end else begin
            pixelx <= pixelx + 10'd1;
         end
      end
   end

   assign raw.hs  = !((pixelx >= HS_FIRST) && (pixelx <= HS_LAST));
   assign raw.vs  = !((pixely >= VS_FIRST) && (pixely <= VS_LAST));
   assign raw.act = (pixelx < H_ACT) && (pixely < V_ACT);

   // Colour is gated by the act bit entering the final stage so rgb_out lines up with blank_n.
   generate
      if (PIPE_DELAY == 1) begin : g_last_raw
         assign last_in = raw;
      end else begin : g_last_stage
         assign last_in = stage[PIPE_DELAY-2];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PIPE_DELAY; i++) begin
            stage[i] <= SYNC_IDLE;
         end
         rgb_out <= '0;
      end else if (pix_tick) begin
         for (int i = PIPE_DELAY - 1; i > 0; i--) begin
            stage[i] <= stage[i-1];
         end
         stage[0] <= raw;
         rgb_out  <= last_in.act ? rgb_in : 24'h000000;
      end
   end

   assign hsync   = stage[PIPE_DELAY-1].hs;
   assign vsync   = stage[PIPE_DELAY-1].vs;
   assign blank_n = stage[PIPE_DELAY-1].act;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster; outputs checked every clk against a tick-count model.
module tb_vga_timing_gen;

   localparam int D  = 2;
   localparam int HA = 20, HF = 4, HS = 6, HB = 5;
   localparam int VA = 10, VF = 2, VS = 2, VB = 3;
   localparam int P  = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] rgb_in = '0;
   logic [9:0]  pixelx, pixely;
   logic        pix_tick, frame_start, hsync, vsync, blank_n, vga_clk;
   logic [23:0] rgb_out;

   int checks = 0;
   int errors = 0;
   int e = 0;
   int mode = 1;
   logic [23:0] samp [int];
   logic [9:0]  xd1, xd2;
   logic [23:0] rom_q;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DELAY(P)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in),
      .pixelx(pixelx), .pixely(pixely), .pix_tick(pix_tick), .frame_start(frame_start),
      .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .rgb_out(rgb_out), .vga_clk(vga_clk)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void xy(input int t, output int x, output int y);
      int n;
      n = t % FT;
      x = n % HT;
      y = n / HT;
   endfunction

   // Edge count since reset release; the whole model is derived from it.
   always @(posedge clk) begin
      if (!rst_n) begin
         e = 0;
         samp.delete();
      end else begin
         e = e + 1;
      end
   end

   // Sprite-side model: pixelx delayed P-1 ticks feeding a 1-clk ROM.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xd1   <= '0;
         xd2   <= '0;
         rom_q <= '0;
      end else begin
         if (pix_tick) begin
            xd1 <= pixelx;
            xd2 <= xd1;
         end
         rom_q <= {xd2, 14'h0};
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0:       rgb_in = 24'($urandom);
            1:       rgb_in = rom_q;
            default: rgb_in = 24'hFFFFFF;
         endcase
      end
   end

   always @(negedge clk) begin : compare
      int div, t, x, y, xo, yo;
      logic etick, ehs, evs, eact;
      logic [23:0] ergb;
      if (!rst_n) begin
         chk("rst_pixelx", pixelx, 0);
         chk("rst_pixely", pixely, 0);
         chk("rst_hsync", hsync, 1);
         chk("rst_vsync", vsync, 1);
         chk("rst_blank_n", blank_n, 0);
         chk("rst_rgb_out", rgb_out, 0);
         chk("rst_pix_tick", pix_tick, 0);
         chk("rst_frame_start", frame_start, 0);
         chk("rst_vga_clk", vga_clk, 0);
      end else begin
         div   = e % D;
         t     = e / D;
         xy(t, x, y);
         etick = (div == D - 1);
         chk("pix_tick", pix_tick, etick);
         chk("vga_clk", vga_clk, div >= D / 2);
         chk("pixelx", pixelx, x);
         chk("pixely", pixely, y);
         chk("frame_start", frame_start, etick && x == HT - 1 && y == VT - 1);
         if (t >= P) begin
            xy(t - P, xo, yo);
            ehs  = !(xo >= HA + HF && xo < HA + HF + HS);
            evs  = !(yo >= VA + VF && yo < VA + VF + VS);
            eact = (xo < HA) && (yo < VA);
            ergb = (eact && samp.exists(t)) ? samp[t] : 24'h0;
         end else begin
            ehs  = 1'b1;
            evs  = 1'b1;
            eact = 1'b0;
            ergb = 24'h0;
         end
         chk("hsync", hsync, ehs);
         chk("vsync", vsync, evs);
         chk("blank_n", blank_n, eact);
         chk("rgb_out", rgb_out, ergb);
         if (etick) samp[t + 1] = rgb_in;
      end
   end

   task automatic wait_tick();
      for (int k = 0; k < 4 * D; k++) begin
         @(negedge clk);
         if (pix_tick) return;
      end
      chk("tick_timeout", 0, 1);
   endtask

   // One frame of ticks: per-frame pulse counts plus mode-specific colour checks.
   task automatic measure(input int m);
      int hs_lo, vs_lo, bl_hi, fs_n;
      bit s0, sl;
      hs_lo = 0; vs_lo = 0; bl_hi = 0; fs_n = 0; s0 = 0; sl = 0;
      for (int n = 0; n < FT; n++) begin
         wait_tick();
         if (!hsync) hs_lo++;
         if (!vsync) vs_lo++;
         if (blank_n) bl_hi++;
         if (frame_start) fs_n++;
         if (m == 1 && blank_n) begin
            if (rgb_out[23:14] == 10'd0) s0 = 1;
            if (rgb_out[23:14] == 10'(HA - 1)) sl = 1;
            chk("rom_low_bits", rgb_out[13:0], 0);
         end
         if (m == 2) chk("white_gate", rgb_out, blank_n ? 24'hFFFFFF : 24'h0);
      end
      chk("hsync_low_ticks", hs_lo, VT * HS);
      chk("vsync_low_ticks", vs_lo, VS * HT);
      chk("blank_high_ticks", bl_hi, HA * VA);
      chk("frame_start_count", fs_n, 1);
      if (m == 1) begin
         chk("rom_x_first_seen", s0, 1);
         chk("rom_x_last_seen", sl, 1);
      end
   endtask

   task automatic pulse_reset(input int hold);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_hsync", hsync, 1);
      chk("async_rst_blank_n", blank_n, 0);
      chk("async_rst_rgb_out", rgb_out, 0);
      chk("async_rst_pixelx", pixelx, 0);
      repeat (hold) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin : main
      bit found;
      int fe, cnt;
      repeat (5) @(posedge clk);
      #1;
      chk("init_hsync", hsync, 1);
      chk("init_vsync", vsync, 1);
      chk("init_rgb_out", rgb_out, 0);
      rst_n = 1'b1;
      repeat (D) @(posedge clk);
      #1;
      chk("first_tick_pixelx", pixelx, 1);
      repeat ((HT - 1) * D) @(posedge clk);
      #1;
      chk("line_wrap_pixelx", pixelx, 0);
      chk("line_wrap_pixely", pixely, 1);

      measure(1);
      mode = 2;
      repeat ((P + 2) * D) @(posedge clk);
      measure(2);

      mode = 0;
      repeat (3) begin
         repeat ($urandom_range(10, FT * D)) @(posedge clk);
         pulse_reset($urandom_range(1, 4));
      end
      measure(0);

      // Reset at a fixed mid-frame point, then time the next frame_start.
      found = 0;
      for (int n = 0; n < 2 * FT * D && !found; n++) begin
         @(posedge clk);
         #1;
         if (pixelx == 10'd12 && pixely == 10'd7) found = 1;
      end
      chk("reach_12_7", found, 1);
      pulse_reset(3);
      found = 0;
      fe = -1;
      for (int n = 0; n < 2 * FT * D && !found; n++) begin
         @(negedge clk);
         if (frame_start) begin
            found = 1;
            fe = e + 1;
         end
      end
      chk("fs_edge_after_reset", fe, FT * D);
      found = 0;
      cnt = 0;
      for (int n = 0; n < 2 * FT * D && !found; n++) begin
         @(negedge clk);
         cnt++;
         if (frame_start) found = 1;
      end
      chk("fs_period_clk", found ? cnt : -1, FT * D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1);
   end

endmodule
